// File: rtl/poly_divmod_q_if.sv
// poly_divmod_q_if
//   Groups the request/status handshake and the three coefficient memory
//   ports of the polynomial divider.
//   - master: the host side. It drives start/deg_n/deg_d/q_en and supplies
//     memory read data.
//   - slave : the divider engine. It drives the memory addresses and write
//     strobes, and reports busy/done/err/deg_q/deg_r/r_zero.
interface poly_divmod_q_if #(
  parameter int W      = 13,
  parameter int ADDR_W = 11
);
  logic              start;
  logic [ADDR_W-1:0] deg_n;
  logic [ADDR_W-1:0] deg_d;
  logic              q_en;
  logic [ADDR_W-1:0] n_raddr;
  logic [W-1:0]      n_rdata;
  logic [ADDR_W-1:0] n_waddr;
  logic [W-1:0]      n_wdata;
  logic              n_we;
  logic [ADDR_W-1:0] d_addr;
  logic [W-1:0]      d_rdata;
  logic [ADDR_W-1:0] q_addr;
  logic [W-1:0]      q_wdata;
  logic              q_we;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W-1:0] deg_q;
  logic [ADDR_W-1:0] deg_r;
  logic              r_zero;

  modport master (
    output start, deg_n, deg_d, q_en, n_rdata, d_rdata,
    input  n_raddr, n_waddr, n_wdata, n_we, d_addr, q_addr, q_wdata, q_we,
    input  busy, done, err, deg_q, deg_r, r_zero
  );

  modport slave (
    input  start, deg_n, deg_d, q_en, n_rdata, d_rdata,
    output n_raddr, n_waddr, n_wdata, n_we, d_addr, q_addr, q_wdata, q_we,
    output busy, done, err, deg_q, deg_r, r_zero
  );
endinterface

// File: rtl/poly_divmod_q.sv
// poly_divmod_q
//   Polynomial long division over Z_MOD: Q = N div D, R = N mod D.
//   The remainder overwrites the N memory in place. Quotient coefficients
//   are written to the Q memory when q_en is set. The inverse of lc(D) is
//   computed internally as lc^(MOD-2) with the shared two-stage modular
//   multiplier.
// Ports
//   clk    : clock. All logic runs on the rising edge.
//   rst_n  : synchronous active-low reset.
//   io     : poly_divmod_q_if.slave. Carries:
//            - the start/deg_n/deg_d/q_en request;
//            - the N read/write port, D read port and Q write port.
//              Read data arrives one cycle after the address.
//            - busy/done/err status and the deg_q/deg_r/r_zero results.
module poly_divmod_q #(
  parameter int MOD     = 4591,
  parameter int W       = 13,
  parameter int ADDR_W  = 11,
  parameter int MAX_DEG = 760
) (
  input logic clk,
  input logic rst_n,
  poly_divmod_q_if.slave io
);
  localparam int                BIT_W     = (W > 1) ? $clog2(W) : 1;
  localparam logic [W-1:0]      MOD_W     = W'(MOD);
  localparam logic [2*W-1:0]    MOD_2W    = (2*W)'(MOD);
  localparam logic [W-1:0]      EXP       = W'(MOD - 2);
  localparam logic [W-1:0]      ONE_W     = W'(1);
  localparam logic [ADDR_W-1:0] MAX_DEG_A = ADDR_W'(MAX_DEG);
  localparam logic [ADDR_W-1:0] ONE_A     = ADDR_W'(1);
  localparam logic [BIT_W-1:0]  ONE_B     = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, LC, INV, QCO, SUB, RDEG, FIN} stateT;

  stateT             stateReg, stateNext;
  logic [2:0]        phaseReg, phaseNext;

  logic [ADDR_W-1:0] degNReg, degDReg, kReg, jReg, scanReg;
  logic [ADDR_W-1:0] degQReg, degRReg;
  logic              qEnReg, errReg, rZeroReg;
  logic [W-1:0]      lcReg, accReg, tReg, nValReg, diffReg;
  logic [BIT_W-1:0]  bitReg;

  // Shared multiplier. Operands presented in cycle c give a reduced result
  // in redReg during cycle c+2.
  logic [W-1:0]      mulA, mulB, redReg;
  logic [2*W-1:0]    prodReg;

  logic [ADDR_W-1:0] nRaddr, nWaddr, dAddr, qAddr;
  logic [W-1:0]      nWdata, qWdata;
  logic              nWe, qWe;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg <= IDLE;
      phaseReg <= '0;
    end else begin
      stateReg <= stateNext;
      phaseReg <= phaseNext;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prodReg <= '0;
      redReg  <= '0;
    end else begin
      prodReg <= {{W{1'b0}}, mulA} * {{W{1'b0}}, mulB};
      redReg  <= W'(prodReg % MOD_2W);
    end
  end

  // Next-state, memory strobes and multiplier operand selection.
  always_comb begin
    stateNext = stateReg;
    phaseNext = phaseReg;
    nRaddr    = '0;
    nWaddr    = '0;
    nWdata    = '0;
    nWe       = 1'b0;
    dAddr     = '0;
    qAddr     = '0;
    qWdata    = '0;
    qWe       = 1'b0;
    mulA      = '0;
    mulB      = '0;
    case (stateReg)
      IDLE: begin
        if (io.start) begin
          stateNext = LC;
          phaseNext = '0;
        end
      end
      LC: begin
        if (phaseReg == 3'd0) begin
          dAddr = degDReg;
          if (degDReg > MAX_DEG_A) stateNext = FIN;
          else                     phaseNext = 3'd1;
        end else begin
          phaseNext = '0;
          if (io.d_rdata == '0)        stateNext = FIN;
          else if (degDReg > degNReg)  stateNext = RDEG;
          else                         stateNext = INV;
        end
      end
      INV: begin
        // Phases 0-2 square the accumulator. Phases 3-5 multiply it by lc
        // when the current exponent bit is set.
        case (phaseReg)
          3'd0: begin
            mulA = accReg;
            mulB = accReg;
            phaseNext = 3'd1;
          end
          3'd1: phaseNext = 3'd2;
          3'd2: begin
            if (EXP[bitReg]) phaseNext = 3'd3;
            else begin
              phaseNext = '0;
              if (bitReg == '0) stateNext = QCO;
            end
          end
          3'd3: begin
            mulA = accReg;
            mulB = lcReg;
            phaseNext = 3'd4;
          end
          3'd4: phaseNext = 3'd5;
          default: begin
            phaseNext = '0;
            if (bitReg == '0) stateNext = QCO;
          end
        endcase
      end
      QCO: begin
        case (phaseReg)
          3'd0: begin
            nRaddr = kReg + degDReg;
            phaseNext = 3'd1;
          end
          3'd1: begin
            mulA = io.n_rdata;
            mulB = accReg;
            phaseNext = 3'd2;
          end
          3'd2: phaseNext = 3'd3;
          default: begin
            qWe       = qEnReg;
            qAddr     = kReg;
            qWdata    = redReg;
            phaseNext = '0;
            stateNext = SUB;
          end
        endcase
      end
      SUB: begin
        case (phaseReg)
          3'd0: begin
            nRaddr = kReg + jReg;
            dAddr  = jReg;
            phaseNext = 3'd1;
          end
          3'd1: begin
            mulA = tReg;
            mulB = io.d_rdata;
            phaseNext = 3'd2;
          end
          3'd2: phaseNext = 3'd3;
          3'd3: phaseNext = 3'd4;
          default: begin
            nWe    = 1'b1;
            nWaddr = kReg + jReg;
            nWdata = diffReg;
            phaseNext = '0;
            if (jReg == degDReg) begin
              if (kReg != '0)          stateNext = QCO;
              else if (degDReg == '0)  stateNext = FIN;
              else                     stateNext = RDEG;
            end
          end
        endcase
      end
      RDEG: begin
        // Pipelined downward scan. Each cycle checks the data for scanReg
        // while the address of the next lower index is already issued.
        if (phaseReg == 3'd0) begin
          nRaddr    = scanReg;
          phaseNext = 3'd1;
        end else if (io.n_rdata != '0 || scanReg == '0) begin
          stateNext = FIN;
          phaseNext = '0;
        end else begin
          nRaddr = scanReg - ONE_A;
        end
      end
      FIN: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      degNReg  <= '0;
      degDReg  <= '0;
      qEnReg   <= 1'b0;
      lcReg    <= '0;
      accReg   <= '0;
      bitReg   <= '0;
      kReg     <= '0;
      jReg     <= '0;
      tReg     <= '0;
      nValReg  <= '0;
      diffReg  <= '0;
      scanReg  <= '0;
      errReg   <= 1'b0;
      degQReg  <= '0;
      degRReg  <= '0;
      rZeroReg <= 1'b0;
    end else begin
      case (stateReg)
        IDLE: begin
          if (io.start) begin
            degNReg  <= io.deg_n;
            degDReg  <= io.deg_d;
            qEnReg   <= io.q_en;
            errReg   <= 1'b0;
            degRReg  <= '0;
            rZeroReg <= 1'b0;
            degQReg  <= (io.deg_d > io.deg_n) ? '0 : io.deg_n - io.deg_d;
          end
        end
        LC: begin
          if (phaseReg == 3'd0) begin
            if (degDReg > MAX_DEG_A) errReg <= 1'b1;
          end else begin
            lcReg   <= io.d_rdata;
            if (io.d_rdata == '0) errReg <= 1'b1;
            kReg    <= degNReg - degDReg;
            jReg    <= '0;
            accReg  <= ONE_W;
            bitReg  <= BIT_W'(W - 1);
            scanReg <= degNReg;
          end
        end
        INV: begin
          if (phaseReg == 3'd2 || phaseReg == 3'd5) accReg <= redReg;
          if ((phaseReg == 3'd2 && !EXP[bitReg]) || phaseReg == 3'd5)
            bitReg <= bitReg - ONE_B;
        end
        QCO: begin
          if (phaseReg == 3'd3) begin
            tReg <= redReg;
            jReg <= '0;
          end
        end
        SUB: begin
          if (phaseReg == 3'd1) nValReg <= io.n_rdata;
          if (phaseReg == 3'd3) begin
            if (nValReg < redReg)
              diffReg <= W'({1'b0, nValReg} + {1'b0, MOD_W} - {1'b0, redReg});
            else
              diffReg <= nValReg - redReg;
          end
          if (phaseReg == 3'd4) begin
            if (jReg == degDReg) begin
              jReg    <= '0;
              kReg    <= kReg - ONE_A;
              // A constant divisor always leaves a zero remainder.
              scanReg <= degDReg - ONE_A;
              if (degDReg == '0) rZeroReg <= 1'b1;
            end else begin
              jReg <= jReg + ONE_A;
            end
          end
        end
        RDEG: begin
          if (phaseReg != 3'd0) begin
            if (io.n_rdata != '0) degRReg  <= scanReg;
            else if (scanReg == '0) rZeroReg <= 1'b1;
            else scanReg <= scanReg - ONE_A;
          end
        end
        default: ;
      endcase
    end
  end

  assign io.n_raddr = nRaddr;
  assign io.n_waddr = nWaddr;
  assign io.n_wdata = nWdata;
  assign io.n_we    = nWe;
  assign io.d_addr  = dAddr;
  assign io.q_addr  = qAddr;
  assign io.q_wdata = qWdata;
  assign io.q_we    = qWe;
  assign io.busy    = (stateReg != IDLE) && (stateReg != FIN);
  assign io.done    = (stateReg == FIN);
  assign io.err     = errReg;
  assign io.deg_q   = degQReg;
  assign io.deg_r   = degRReg;
  assign io.r_zero  = rZeroReg;
endmodule

// File: tb/tb_poly_divmod_q.sv
module tb_poly_divmod_q;
  localparam int MOD     = 4591;
  localparam int W       = 13;
  localparam int ADDR_W  = 11;
  localparam int MAX_DEG = 760;
  localparam int MEM_D   = 1 << ADDR_W;
  localparam int QSENT   = (1 << W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  poly_divmod_q_if #(.W(W), .ADDR_W(ADDR_W)) bus ();

  poly_divmod_q #(.MOD(MOD), .W(W), .ADDR_W(ADDR_W), .MAX_DEG(MAX_DEG)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .io   (bus.slave)
  );

  logic [W-1:0] nMem [MEM_D];
  logic [W-1:0] dMem [MEM_D];
  logic [W-1:0] qMem [MEM_D];
  int nInit [MEM_D];
  int dInit [MEM_D];

  int compared = 0;
  int mismatched = 0;
  int nWeCnt, qWeCnt, doneCnt, badAddrCnt, curDn;

  // Memory models with one-cycle registered reads.
  always @(posedge clk) begin
    bus.n_rdata <= nMem[bus.n_raddr];
    bus.d_rdata <= dMem[bus.d_addr];
    if (bus.n_we) nMem[bus.n_waddr] <= bus.n_wdata;
    if (bus.q_we) qMem[bus.q_addr] <= bus.q_wdata;
  end

  always @(negedge clk) begin
    if (bus.n_we) nWeCnt++;
    if (bus.q_we) qWeCnt++;
    if (bus.done) doneCnt++;
    if (bus.busy && (int'(bus.n_raddr) > curDn || (bus.n_we && int'(bus.n_waddr) > curDn)))
      badAddrCnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clearInit();
    for (int i = 0; i < MEM_D; i++) begin
      nInit[i] = 0;
      dInit[i] = 0;
    end
  endtask

  task automatic randInit(input int dn, input int dd);
    clearInit();
    for (int i = 0; i <= dn; i++) nInit[i] = $urandom_range(MOD - 1, 0);
    for (int i = 0; i <= dd; i++) dInit[i] = $urandom_range(MOD - 1, 0);
    dInit[dd] = $urandom_range(MOD - 1, 1);
  endtask

  task automatic loadMem();
    for (int i = 0; i < MEM_D; i++) begin
      nMem[i] = W'(nInit[i]);
      dMem[i] = W'(dInit[i]);
      qMem[i] = W'(QSENT);
    end
  endtask

  // Runs one division and checks the results against a schoolbook model.
  task automatic runOp(input string tag, input int dn, input int dd, input bit qe,
                       input bit secondStart, output int cyc);
    int rem [MEM_D];
    int qRef [MEM_D];
    int dq, inv, t, bound, expNWe, expQWe, expDr, badN, badQ, top;
    bit expErr, divides, expRz;
    loadMem();
    for (int i = 0; i < MEM_D; i++) begin
      rem[i] = nInit[i];
      qRef[i] = QSENT;
    end
    expErr  = (dd > MAX_DEG) || (dInit[dd] == 0);
    divides = !expErr && (dd <= dn);
    dq = (dd > dn) ? 0 : dn - dd;
    expNWe = 0; expQWe = 0; expRz = 0; expDr = 0;
    if (divides) begin
      inv = 0;
      for (int x = 1; x < MOD; x++)
        if ((dInit[dd] * x) % MOD == 1) begin
          inv = x;
          break;
        end
      for (int k = dq; k >= 0; k--) begin
        t = (rem[k + dd] * inv) % MOD;
        if (qe) qRef[k] = t;
        for (int j = 0; j <= dd; j++) begin
          rem[k + j] = rem[k + j] - (t * dInit[j]) % MOD;
          if (rem[k + j] < 0) rem[k + j] += MOD;
        end
      end
      expNWe = (dq + 1) * (dd + 1);
      expQWe = qe ? dq + 1 : 0;
    end
    if (!expErr) begin
      top = divides ? dd - 1 : dn;
      expRz = 1;
      for (int i = top; i >= 0; i--)
        if (rem[i] != 0) begin
          expDr = i;
          expRz = 0;
          break;
        end
    end

    curDn = dn; nWeCnt = 0; qWeCnt = 0; doneCnt = 0; badAddrCnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.deg_n = ADDR_W'(dn);
    bus.deg_d = ADDR_W'(dd);
    bus.q_en  = qe;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 1;
    bound = 5 * (dq + 1) * (dd + 2) + 8 * W + dn + 8;
    while (!bus.done && cyc < bound + 20) begin
      if (secondStart && cyc == 3) begin
        bus.start = 1'b1;
        bus.deg_n = '0;
        bus.deg_d = '0;
        bus.q_en  = ~qe;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_latency"}, cyc <= bound, 1);
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_err"}, bus.err, expErr);
    if (!expErr) begin
      check({tag, "_deg_q"}, bus.deg_q, dq);
      check({tag, "_deg_r"}, bus.deg_r, expDr);
      check({tag, "_r_zero"}, bus.r_zero, expRz);
    end
    repeat (3) @(negedge clk);
    check({tag, "_done_count"}, doneCnt, 1);
    check({tag, "_err_held"}, bus.err, expErr);
    check({tag, "_n_we_count"}, nWeCnt, expNWe);
    check({tag, "_q_we_count"}, qWeCnt, expQWe);
    check({tag, "_addr_above_deg_n"}, badAddrCnt, 0);
    badN = 0;
    badQ = 0;
    for (int i = 0; i < MEM_D; i++) begin
      if (int'(nMem[i]) != rem[i]) badN++;
      if (int'(qMem[i]) != qRef[i]) badQ++;
    end
    check({tag, "_r_coef_errors"}, badN, 0);
    check({tag, "_q_coef_errors"}, badQ, 0);
    $display("op %s: deg_n=%0d deg_d=%0d q_en=%0d cycles=%0d deg_r=%0d r_zero=%0d err=%0d",
             tag, dn, dd, qe, cyc, bus.deg_r, bus.r_zero, bus.err);
  endtask

  initial begin
    int cyc, dn, dd;
    bus.start = 1'b0;
    bus.deg_n = '0;
    bus.deg_d = '0;
    bus.q_en  = 1'b0;
    curDn = 0;
    clearInit();
    loadMem();

    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_err", bus.err, 0);
    check("rst_n_we", bus.n_we, 0);
    check("rst_q_we", bus.q_we, 0);
    check("rst_deg_q", bus.deg_q, 0);
    check("rst_deg_r", bus.deg_r, 0);
    check("rst_r_zero", bus.r_zero, 0);
    check("rst_addrs", {bus.n_raddr, bus.d_addr, bus.q_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // (x^2+3x+2) / (x+1)
    clearInit();
    nInit[0] = 2; nInit[1] = 3; nInit[2] = 1;
    dInit[0] = 1; dInit[1] = 1;
    runOp("quad_by_lin", 2, 1, 1'b1, 1'b0, cyc);
    check("quad_q0", qMem[0], 2);
    check("quad_q1", qMem[1], 1);
    check("quad_r0", nMem[0], 0);

    // (2x^3+1) / (2x): needs inv(2) = 2296
    clearInit();
    nInit[0] = 1; nInit[3] = 2;
    dInit[1] = 2;
    runOp("cubic_by_2x", 3, 1, 1'b1, 1'b0, cyc);
    check("cubic_q2", qMem[2], 1);
    check("cubic_q0", qMem[0], 0);
    check("cubic_r0", nMem[0], 1);

    // x / (x+1): remainder wraps to MOD-1
    clearInit();
    nInit[1] = 1;
    dInit[0] = 1; dInit[1] = 1;
    runOp("wrap", 1, 1, 1'b1, 1'b0, cyc);
    check("wrap_r0", nMem[0], MOD - 1);
    check("wrap_q0", qMem[0], 1);

    // deg_d > deg_n: nothing written
    clearInit();
    nInit[0] = 7; nInit[1] = 5;
    dInit[0] = 9; dInit[1] = 4; dInit[2] = 3;
    runOp("no_div", 1, 2, 1'b1, 1'b0, cyc);
    check("no_div_fast", cyc <= 10, 1);

    // zero leading coefficient, then a valid op must clear err
    clearInit();
    nInit[0] = 1; nInit[1] = 2; nInit[2] = 3;
    dInit[0] = 4;
    runOp("lc_zero", 2, 1, 1'b1, 1'b0, cyc);
    clearInit();
    nInit[0] = 2; nInit[1] = 3; nInit[2] = 1;
    dInit[0] = 1; dInit[1] = 1;
    runOp("err_clear", 2, 1, 1'b1, 1'b0, cyc);

    randInit(10, MAX_DEG + 1);
    runOp("deg_d_too_big", 10, MAX_DEG + 1, 1'b1, 1'b0, cyc);

    // reset during SUB
    randInit(10, 4);
    loadMem();
    curDn = 10; doneCnt = 0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.deg_n = ADDR_W'(10);
    bus.deg_d = ADDR_W'(4);
    bus.q_en  = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    cyc = 0;
    while (!bus.n_we && cyc < 500) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_mid_sub_reached", bus.n_we, 1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_busy", bus.busy, 0);
    check("rst_mid_n_we", bus.n_we, 0);
    check("rst_mid_q_we", bus.q_we, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_mid_no_done", doneCnt, 0);
    runOp("after_reset", 10, 4, 1'b1, 1'b0, cyc);

    // constant divisor: remainder is zero without a scan
    randInit(4, 0);
    runOp("const_div", 4, 0, 1'b1, 1'b0, cyc);

    // remainder-only mode on the same operands, with a start while busy
    randInit(12, 5);
    runOp("qen1", 12, 5, 1'b1, 1'b0, cyc);
    runOp("qen0_restart", 12, 5, 1'b0, 1'b1, cyc);

    randInit(MAX_DEG, MAX_DEG);
    runOp("max_deg", MAX_DEG, MAX_DEG, 1'b1, 1'b0, cyc);

    for (int r = 0; r < 6; r++) begin
      dn = $urandom_range(24, 0);
      dd = $urandom_range(dn + 3, 0);
      randInit(dn, dd);
      runOp($sformatf("rand%0d", r), dn, dd, 1'($urandom_range(1, 0)), 1'b0, cyc);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
